slave_bus_arbiter: RTL and testbench
====================================

# slave_bus_arbiter

Round-robin arbiter and sequencer for the shared 8-bit slave output bus, to which every frame-producing slave (gpio_int and its peers) attaches via a request/grant/latch trio. It grants one requesting slave at a time and drains that slave's entire frame byte by byte through the shared `sl_data_latch` strobe. Each byte is forwarded to a single ready/valid byte stream feeding the host uplink. It holds grant for a whole frame, so frames from different slaves never interleave.

## Interface
- `NUM_SLAVES`, 4: number of requesters, 2..8.
- `MAX_FRAME_BYTES`, 255: byte cap per grant, 1..255. Reaching it forces release.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `sl_arb_request` input NUM_SLAVES: per-slave frame-pending flag.
- `slave_enable` input NUM_SLAVES: per-slave enable mask. Disabled slaves are never granted.
- `sl_arb_grant` output NUM_SLAVES: one-hot or zero grant. Registered.
- `sl_data_latch` output 1: shared one-cycle pop strobe. Registered.
- `sl_data` input 8: shared tri-state bus, read side only.
- `out_data` output 8: forwarded byte. Registered.
- `out_valid` output 1: out_data is valid.
- `out_sof` output 1: qualifies out_data as the first byte of a frame.
- `out_ready` input 1: downstream accepts when out_valid & out_ready.
- `frame_abort` output 1: one-cycle pulse when a grant is force-released at MAX_FRAME_BYTES.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Slave bus contract: while a slave is granted, its head byte is present on `sl_data` (first-word-fall-through). A cycle with `sl_data_latch` high pops that byte. `sl_arb_request` stays high while any byte of the current frame remains.
- FSM states: IDLE, TURN, SAMPLE, PRESENT.
- IDLE:
  - Candidates are `sl_arb_request & slave_enable`.
  - If any candidate exists, select the first one strictly after `last_idx`, searching upward with wrap-around.
  - Register its one-hot grant, clear byte_cnt, set sof_pend, go to TURN.
- TURN: one bus-turnaround cycle with grant held. Go to SAMPLE.
- SAMPLE, when the granted request is high and byte_cnt < MAX_FRAME_BYTES:
  - capture `sl_data` into out_data;
  - set out_sof = sof_pend, then clear sof_pend;
  - pulse `sl_data_latch` (registered, so it is high during the next cycle);
  - byte_cnt += 1;
  - go to PRESENT.
- SAMPLE, when the granted request is low: drop grant, set last_idx = granted index, go to IDLE.
- SAMPLE, when byte_cnt == MAX_FRAME_BYTES: drop grant, pulse frame_abort, update last_idx, go to IDLE. Remaining bytes stay in the slave.
- PRESENT: out_valid high. Go to SAMPLE on the cycle where out_ready is high. out_data and out_sof are stable while waiting.
- byte_cnt is 8 bits and never wraps, because the cap check precedes the increment.
- `slave_enable` is sampled only in IDLE. Deasserting it mid-frame does not preempt the current frame.
- A request that drops mid-frame ends the frame at the next SAMPLE; no partial-frame flag is raised.
- Reset, including mid-frame: go to IDLE with grant = 0, latch = 0, out_valid = 0, out_sof = 0, frame_abort = 0, out_data = 0, byte_cnt = 0, last_idx = NUM_SLAVES-1 (slave 0 wins first). A frame in flight is abandoned and not resumed.

## Timing
- From request high in IDLE (cycle N): grant at N+1, first sample at N+2, latch high and out_valid high at N+3.
- Per byte with out_ready held high: PRESENT→SAMPLE→PRESENT, giving 2 cycles per byte.
- End of frame: grant drops one cycle after the SAMPLE that sees the request low. The earliest next grant is 2 cycles after that, so there is at least one idle-grant cycle between owners.
- `sl_data_latch` is never high while grant is zero or changing.
- out_valid never drops without a handshake, except at reset.

## Test plan
- Single frame: slave 1 presents 5 bytes 67,0A,05,6C,3F with out_ready=1 → stream 67(sof),0A,05,6C,3F; exactly 5 latch pulses; grant[1] drops; busy returns to 0.
- Round-robin: slaves 0 and 2 request continuously, with slave 0 granted last → order is 2,0,2,0, whole frames, with no byte interleaving.
- Backpressure: out_ready low for 7 cycles on byte 2 → out_data and out_sof held; no extra latch; no byte lost or duplicated.
- Cap: MAX_FRAME_BYTES=4 with a 6-byte frame → 4 bytes forwarded, frame_abort pulses once, grant released. The next grant of the same slave emits the remaining 2 bytes with sof on the first of them.
- Enable mask: slave 3 requests with slave_enable[3]=0 → never granted. Set enable=1 → granted within 2 cycles.
- Mid-frame reset after byte 2 → the next cycle shows grant=0, out_valid=0, latch=0. With the request still high, slave 0 is regranted first.

Source files
------------

// File: rtl/slave_bus_arbiter.sv
// Round-robin arbiter and frame sequencer for the shared 8-bit slave output bus.
// One slave is granted at a time and its whole frame is drained byte by byte
// through the shared sl_data_latch strobe. Each byte is forwarded to a
// ready/valid byte stream with a start-of-frame qualifier.
module slave_bus_arbiter #(
    parameter int NUM_SLAVES      = 4,
    parameter int MAX_FRAME_BYTES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SLAVES-1:0] sl_arb_request,
    input  logic [NUM_SLAVES-1:0] slave_enable,
    output logic [NUM_SLAVES-1:0] sl_arb_grant,
    output logic                  sl_data_latch,
    input  logic [7:0]            sl_data,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    output logic                  out_sof,
    input  logic                  out_ready,
    output logic                  frame_abort,
    output logic                  busy
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [NUM_SLAVES-1:0] GNT_ONE = {{(NUM_SLAVES-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]      LAST_RST = IDX_W'(NUM_SLAVES - 1);
    localparam logic [7:0]            CAP     = 8'(MAX_FRAME_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN    = 2'd1,
        ST_SAMPLE  = 2'd2,
        ST_PRESENT = 2'd3
    } state_t;

    // Round-robin pick: first candidate strictly after 'last', searching
    // upward with wrap-around. Returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [NUM_SLAVES-1:0] cand,
        input logic [IDX_W-1:0]      last
    );
        logic             found;
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] idx;
        int               pos;
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= NUM_SLAVES; k++) begin
            pos = int'(last) + k;
            if (pos >= NUM_SLAVES) begin
                pos = pos - NUM_SLAVES;
            end else begin
                pos = pos;
            end
            idx = IDX_W'(pos);
            if (!found && cand[idx]) begin
                found = 1'b1;
                sel   = idx;
            end else begin
                found = found;
            end
        end
        return {found, sel};
    endfunction

    // Registered state
    state_t                  state_r;
    logic [NUM_SLAVES-1:0]   grant_r;
    logic                    latch_r;
    logic [7:0]              out_data_r;
    logic                    out_sof_r;
    logic                    out_valid_r;
    logic                    frame_abort_r;
    logic                    busy_r;
    logic [7:0]              byte_cnt_r;
    logic [IDX_W-1:0]        last_idx_r;
    logic [IDX_W-1:0]        gnt_idx_r;
    logic                    sof_pend_r;

    // Next-state values
    state_t                  state_s;
    logic [NUM_SLAVES-1:0]   grant_s;
    logic                    latch_s;
    logic [7:0]              out_data_s;
    logic                    out_sof_s;
    logic                    out_valid_s;
    logic                    frame_abort_s;
    logic                    busy_s;
    logic [7:0]              byte_cnt_s;
    logic [IDX_W-1:0]        last_idx_s;
    logic [IDX_W-1:0]        gnt_idx_s;
    logic                    sof_pend_s;

    // Arbitration helpers
    logic [NUM_SLAVES-1:0]   cand_s;
    logic                    pick_found_s;
    logic [IDX_W-1:0]        pick_sel_s;
    logic                    req_gnt_s;

    assign cand_s                      = sl_arb_request & slave_enable;
    assign {pick_found_s, pick_sel_s}  = rr_pick(cand_s, last_idx_r);
    assign req_gnt_s                   = |(sl_arb_request & grant_r);

    // Next-state and output decode; grant is held for the whole frame
    always_comb begin
        state_s       = state_r;
        grant_s       = grant_r;
        latch_s       = 1'b0;
        out_data_s    = out_data_r;
        out_sof_s     = out_sof_r;
        frame_abort_s = 1'b0;
        byte_cnt_s    = byte_cnt_r;
        last_idx_s    = last_idx_r;
        gnt_idx_s     = gnt_idx_r;
        sof_pend_s    = sof_pend_r;

        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_s    = GNT_ONE << pick_sel_s;
                    gnt_idx_s  = pick_sel_s;
                    byte_cnt_s = 8'd0;
                    sof_pend_s = 1'b1;
                    state_s    = ST_TURN;
                end else begin
                    grant_s    = '0;
                end
            end
            ST_TURN: begin
                state_s = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (!req_gnt_s) begin
                    // Frame finished normally: release the bus.
                    grant_s    = '0;
                    last_idx_s = gnt_idx_r;
                    state_s    = ST_IDLE;
                end else if (byte_cnt_r < CAP) begin
                    // Capture the head byte and pop it on the following cycle.
                    out_data_s = sl_data;
                    out_sof_s  = sof_pend_r;
                    sof_pend_s = 1'b0;
                    latch_s    = 1'b1;
                    byte_cnt_s = byte_cnt_r + 8'd1;
                    state_s    = ST_PRESENT;
                end else begin
                    // Byte cap reached: force release, leftovers stay in the slave.
                    grant_s       = '0;
                    frame_abort_s = 1'b1;
                    last_idx_s    = gnt_idx_r;
                    state_s       = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    state_s = ST_SAMPLE;
                end else begin
                    state_s = ST_PRESENT;
                end
            end
            default: begin
                grant_s = '0;
                state_s = ST_IDLE;
            end
        endcase

        out_valid_s = (state_s == ST_PRESENT);
        busy_s      = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            grant_r       <= '0;
            latch_r       <= 1'b0;
            out_data_r    <= 8'd0;
            out_sof_r     <= 1'b0;
            out_valid_r   <= 1'b0;
            frame_abort_r <= 1'b0;
            busy_r        <= 1'b0;
            byte_cnt_r    <= 8'd0;
            last_idx_r    <= LAST_RST;
            gnt_idx_r     <= '0;
            sof_pend_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            grant_r       <= grant_s;
            latch_r       <= latch_s;
            out_data_r    <= out_data_s;
            out_sof_r     <= out_sof_s;
            out_valid_r   <= out_valid_s;
            frame_abort_r <= frame_abort_s;
            busy_r        <= busy_s;
            byte_cnt_r    <= byte_cnt_s;
            last_idx_r    <= last_idx_s;
            gnt_idx_r     <= gnt_idx_s;
            sof_pend_r    <= sof_pend_s;
        end
    end

    assign sl_arb_grant  = grant_r;
    assign sl_data_latch = latch_r;
    assign out_data      = out_data_r;
    assign out_sof       = out_sof_r;
    assign out_valid     = out_valid_r;
    assign frame_abort   = frame_abort_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_slave_bus_arbiter.sv
// Directed bench for slave_bus_arbiter: a default instance (cap 255) with a
// four-slave FIFO model, and a cap-4 instance with a single-slave model.
module tb_slave_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset  = 1'b1;
    logic [3:0] enable = 4'hF;
    logic       ready  = 1'b1;
    logic       b_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    // Instance A signals and slave model
    logic [3:0] a_req, a_gnt;
    logic       a_latch, a_valid, a_sof, a_abort, a_busy;
    logic [7:0] a_sl_data, a_data;
    logic [7:0] a_mem [4][64];
    logic       a_eof [4][64];
    int         a_wr [4];
    int         a_rd [4]   = '{default: 0};
    logic       a_hold [4] = '{default: 1'b0};
    logic [7:0] a_log_d [64];
    logic       a_log_sof [64];
    int         a_log_src [64];
    int         a_log_n   = 0;
    int         a_latch_n = 0;
    int         a_viol    = 0;

    // Instance B signals and slave model
    logic [3:0] b_req, b_gnt;
    logic       b_latch, b_valid, b_sof, b_abort, b_busy;
    logic [7:0] b_sl_data, b_data;
    logic [7:0] b_mem [16];
    int         b_wr;
    int         b_rd = 0;
    logic [7:0] b_log_d [16];
    logic       b_log_sof [16];
    int         b_log_n   = 0;
    int         b_abort_n = 0;

    slave_bus_arbiter #(.NUM_SLAVES(4), .MAX_FRAME_BYTES(255)) u_dut_a (
        .clk(clk), .reset(reset), .sl_arb_request(a_req), .slave_enable(enable),
        .sl_arb_grant(a_gnt), .sl_data_latch(a_latch), .sl_data(a_sl_data),
        .out_data(a_data), .out_valid(a_valid), .out_sof(a_sof), .out_ready(ready),
        .frame_abort(a_abort), .busy(a_busy)
    );

    slave_bus_arbiter #(.NUM_SLAVES(4), .MAX_FRAME_BYTES(4)) u_dut_b (
        .clk(clk), .reset(reset), .sl_arb_request(b_req), .slave_enable(enable),
        .sl_arb_grant(b_gnt), .sl_data_latch(b_latch), .sl_data(b_sl_data),
        .out_data(b_data), .out_valid(b_valid), .out_sof(b_sof), .out_ready(b_ready),
        .frame_abort(b_abort), .busy(b_busy)
    );

    function automatic int oh2idx(input logic [3:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

    // Slave A model: request while bytes remain, dropped after the last byte of a frame
    always_comb begin
        a_sl_data = 8'h00;
        for (int s = 0; s < 4; s++) begin
            a_req[s] = (a_rd[s] < a_wr[s]) && !(a_hold[s] && a_gnt[s]);
            if (a_gnt[s]) a_sl_data = a_mem[s][a_rd[s]];
        end
    end

    // Slave A pop on latch
    always @(posedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (a_latch && a_gnt[s] && (a_rd[s] < a_wr[s])) begin
                a_rd[s]   <= a_rd[s] + 1;
                a_hold[s] <= a_eof[s][a_rd[s]];
            end else if (!a_gnt[s]) begin
                a_hold[s] <= 1'b0;
            end
        end
    end

    // Slave B model: slave 0 only, one continuous frame
    always_comb begin
        b_req     = {3'b000, (b_rd < b_wr)};
        b_sl_data = b_gnt[0] ? b_mem[b_rd] : 8'h00;
    end

    always @(posedge clk) begin
        if (b_latch && b_gnt[0] && (b_rd < b_wr)) b_rd <= b_rd + 1;
    end

    // Stream monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (a_valid && ready && a_log_n < 64) begin
            a_log_d[a_log_n]   <= a_data;
            a_log_sof[a_log_n] <= a_sof;
            a_log_src[a_log_n] <= oh2idx(a_gnt);
            a_log_n            <= a_log_n + 1;
        end
        if (a_latch) a_latch_n <= a_latch_n + 1;
        if (a_latch && a_gnt == 4'b0000) a_viol <= a_viol + 1;
        if (b_valid && b_ready && b_log_n < 16) begin
            b_log_d[b_log_n]   <= b_data;
            b_log_sof[b_log_n] <= b_sof;
            b_log_n            <= b_log_n + 1;
        end
        if (b_abort) b_abort_n <= b_abort_n + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input int s, input logic [7:0] d, input logic e);
        a_mem[s][a_wr[s]] = d;
        a_eof[s][a_wr[s]] = e;
        a_wr[s] = a_wr[s] + 1;
    endtask

    task automatic wait_idle_a(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            step();
            if (!a_busy) break;
        end
        chk(tag, {31'd0, a_busy}, 32'd0);
    endtask

    task automatic wait_log_a(input string tag, input int n, input int max);
        for (int i = 0; i < max; i++) begin
            step();
            if (a_log_n >= n) break;
        end
        chk(tag, {31'd0, (a_log_n >= n)}, 32'd1);
    endtask

    initial begin
        int base;
        int lbase;
        logic [7:0] f1 [5];
        logic [7:0] rr_d [8];
        int         rr_s [8];
        logic [7:0] bp [3];
        f1   = '{8'h67, 8'h0A, 8'h05, 8'h6C, 8'h3F};
        rr_d = '{8'h21, 8'h22, 8'h01, 8'h02, 8'h23, 8'h24, 8'h03, 8'h04};
        rr_s = '{2, 2, 0, 0, 2, 2, 0, 0};
        bp   = '{8'hB1, 8'hB2, 8'hB3};
        a_wr = '{default: 0};
        b_wr = 0;

        // Reset state
        repeat (3) step();
        chk("rst_gnt",   {28'd0, a_gnt}, 32'd0);
        chk("rst_latch", {31'd0, a_latch}, 32'd0);
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_sof",   {31'd0, a_sof}, 32'd0);
        chk("rst_data",  {24'd0, a_data}, 32'd0);
        chk("rst_abort", {31'd0, a_abort}, 32'd0);
        chk("rst_busy",  {31'd0, a_busy}, 32'd0);
        chk("rst_b_gnt", {28'd0, b_gnt}, 32'd0);
        reset = 1'b0;
        step();

        // Single frame from slave 1 with exact first-byte latency
        base  = a_log_n;
        lbase = a_latch_n;
        for (int i = 0; i < 5; i++) push_a(1, f1[i], (i == 4));
        chk("t1_gnt_n0", {28'd0, a_gnt}, 32'd0);
        step();
        chk("t1_gnt_n1", {28'd0, a_gnt}, 32'h2);
        chk("t1_valid_n1", {31'd0, a_valid}, 32'd0);
        step();
        chk("t1_valid_n2", {31'd0, a_valid}, 32'd0);
        chk("t1_latch_n2", {31'd0, a_latch}, 32'd0);
        step();
        chk("t1_valid_n3", {31'd0, a_valid}, 32'd1);
        chk("t1_latch_n3", {31'd0, a_latch}, 32'd1);
        chk("t1_data_n3",  {24'd0, a_data}, 32'h67);
        chk("t1_sof_n3",   {31'd0, a_sof}, 32'd1);
        wait_idle_a("t1_idle", 100);
        chk("t1_count", a_log_n - base, 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t1_byte%0d", i), {24'd0, a_log_d[base+i]}, {24'd0, f1[i]});
            chk($sformatf("t1_sof%0d", i), {31'd0, a_log_sof[base+i]}, {31'd0, (i == 0)});
            chk($sformatf("t1_src%0d", i), a_log_src[base+i], 32'd1);
        end
        chk("t1_latches", a_latch_n - lbase, 32'd5);
        chk("t1_gnt_end", {28'd0, a_gnt}, 32'd0);

        // Prelude so that slave 0 is the last owner
        base = a_log_n;
        push_a(0, 8'h5A, 1'b1);
        wait_log_a("pre_log", base + 1, 50);
        wait_idle_a("pre_idle", 50);

        // Round-robin between slaves 0 and 2, two frames each
        base = a_log_n;
        push_a(0, 8'h01, 1'b0); push_a(0, 8'h02, 1'b1);
        push_a(0, 8'h03, 1'b0); push_a(0, 8'h04, 1'b1);
        push_a(2, 8'h21, 1'b0); push_a(2, 8'h22, 1'b1);
        push_a(2, 8'h23, 1'b0); push_a(2, 8'h24, 1'b1);
        wait_log_a("rr_log", base + 8, 200);
        wait_idle_a("rr_idle", 50);
        chk("rr_count", a_log_n - base, 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_byte%0d", i), {24'd0, a_log_d[base+i]}, {24'd0, rr_d[i]});
            chk($sformatf("rr_src%0d", i), a_log_src[base+i], rr_s[i]);
            chk($sformatf("rr_sof%0d", i), {31'd0, a_log_sof[base+i]}, {31'd0, (i % 2 == 0)});
        end

        // Backpressure on byte 2
        base  = a_log_n;
        lbase = a_latch_n;
        for (int i = 0; i < 3; i++) push_a(1, bp[i], (i == 2));
        wait_log_a("bp_first", base + 1, 50);
        ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("bp_valid%0d", i), {31'd0, a_valid}, 32'd1);
            chk($sformatf("bp_data%0d", i), {24'd0, a_data}, 32'hB2);
            chk($sformatf("bp_sof%0d", i), {31'd0, a_sof}, 32'd0);
            if (i > 0) chk($sformatf("bp_latch%0d", i), {31'd0, a_latch}, 32'd0);
        end
        ready = 1'b1;
        wait_idle_a("bp_idle", 50);
        chk("bp_count", a_log_n - base, 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_byte%0d", i), {24'd0, a_log_d[base+i]}, {24'd0, bp[i]});
        end
        chk("bp_latches", a_latch_n - lbase, 32'd3);

        // Enable mask on slave 3
        enable = 4'b0111;
        base = a_log_n;
        push_a(3, 8'hC3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("en_off%0d", i), {31'd0, a_gnt[3]}, 32'd0);
        end
        chk("en_off_busy", {31'd0, a_busy}, 32'd0);
        enable = 4'hF;
        for (int i = 0; i < 2; i++) begin
            step();
            if (a_gnt[3]) break;
        end
        chk("en_on_gnt", {28'd0, a_gnt}, 32'h8);
        wait_idle_a("en_idle", 50);
        chk("en_byte", {24'd0, a_log_d[base]}, 32'hC3);
        chk("en_src", a_log_src[base], 32'd3);

        // Mid-frame reset after byte 2 of slave 0
        base = a_log_n;
        for (int i = 0; i < 5; i++) push_a(0, 8'h11 + 8'(i), (i == 4));
        wait_log_a("mr_two", base + 2, 50);
        reset = 1'b1;
        step();
        chk("mr_gnt",   {28'd0, a_gnt}, 32'd0);
        chk("mr_valid", {31'd0, a_valid}, 32'd0);
        chk("mr_latch", {31'd0, a_latch}, 32'd0);
        chk("mr_busy",  {31'd0, a_busy}, 32'd0);
        chk("mr_data",  {24'd0, a_data}, 32'd0);
        chk("mr_sof",   {31'd0, a_sof}, 32'd0);
        reset = 1'b0;
        step();
        chk("mr_regrant", {28'd0, a_gnt}, 32'h1);
        wait_idle_a("mr_idle", 50);
        chk("mr_count", a_log_n - base, 32'd5);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mr_byte%0d", i), {24'd0, a_log_d[base+2+i]}, {24'd0, 8'h13 + 8'(i)});
            chk($sformatf("mr_sof%0d", i), {31'd0, a_log_sof[base+2+i]}, {31'd0, (i == 0)});
        end

        // Byte cap of 4 on instance B with a 6-byte frame
        for (int i = 0; i < 6; i++) begin
            b_mem[b_wr] = 8'hA0 + 8'(i);
            b_wr = b_wr + 1;
        end
        for (int i = 0; i < 200; i++) begin
            step();
            if (b_log_n >= 6 && !b_busy) break;
        end
        chk("cap_count", b_log_n, 32'd6);
        chk("cap_busy", {31'd0, b_busy}, 32'd0);
        chk("cap_aborts", b_abort_n, 32'd1);
        chk("cap_gnt", {28'd0, b_gnt}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("cap_byte%0d", i), {24'd0, b_log_d[i]}, {24'd0, 8'hA0 + 8'(i)});
            chk($sformatf("cap_sof%0d", i), {31'd0, b_log_sof[i]}, {31'd0, (i == 0 || i == 4)});
        end

        chk("latch_without_grant", a_viol, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
